icape_warmboot_seq: RTL and testbench

// Wishbone bus master that sits directly upstream of the ICAPE2 register

---
 rtl/icape_warmboot_seq_pkg.sv | 27 ++
 rtl/icape_warmboot_seq_if.sv | 23 ++
 rtl/icape_warmboot_seq_wb_single_xact.sv | 77 +++++++
 rtl/icape_warmboot_seq.sv | 148 ++++++++++++++
 tb/tb_icape_warmboot_seq.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/icape_warmboot_seq_pkg.sv
// Package: icape_warmboot_seq_pkg
// Purpose: shared constants and encodings for the ICAPE2 warm-boot sequencer.
//   REG_CMD / REG_WBSTAR  register addresses in the ICAPE2 slave's 5-bit space
//   CMD_IPROG             command word that triggers reconfiguration
//   state_t               sequencer FSM states
//   err_code_t            encoding reported on o_err_code
package icape_warmboot_seq_pkg;

  localparam logic [4:0]  REG_CMD    = 5'h04;
  localparam logic [4:0]  REG_WBSTAR = 5'h10;
  localparam logic [31:0] CMD_IPROG  = 32'h0000_000f;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_STAR = 3'd1,
    ST_RD_STAR = 3'd2,
    ST_CHECK   = 3'd3,
    ST_WR_CMD  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_TIMEOUT = 2'd1,
    ERR_VERIFY  = 2'd2
  } err_code_t;

endpackage

// File: rtl/icape_warmboot_seq_if.sv
// Interface: icape_warmboot_seq_if
// Purpose: pipelined Wishbone link between the warm-boot sequencer (master)
//   and the ICAPE2 register slave.
//   cyc, stb, we    master cycle / strobe / write enable
//   addr[4:0]       register address
//   wdata[31:0]     write data
//   ack, stall      slave acknowledge / stall
//   rdata[31:0]     slave read data, valid with ack
interface icape_warmboot_seq_if;

  logic        cyc;
  logic        stb;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic        ack;
  logic        stall;
  logic [31:0] rdata;

  modport master (output cyc, stb, we, addr, wdata, input ack, stall, rdata);
  modport slave  (input cyc, stb, we, addr, wdata, output ack, stall, rdata);

endinterface

// File: rtl/icape_warmboot_seq_wb_single_xact.sv
// Module: wb_single_xact
// Purpose: runs exactly one Wishbone transaction per req pulse, with an
//   ack timeout.
//   i_clk, i_reset_n   clock, asynchronous active-low reset
//   req                one-cycle launch; we/addr/data are captured with it
//   we, addr, data     transaction attributes
//   ack                pulse: slave acked while our cycle was open
//   rdata              slave read data, meaningful with ack
//   timeout            pulse: counter saturated without ack; cyc drops next
//   wb                 Wishbone master port
module wb_single_xact #(
  parameter int TIMEOUT_LG = 10
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic                        req,
  input  logic                        we,
  input  logic [4:0]                  addr,
  input  logic [31:0]                 data,
  output logic                        ack,
  output logic [31:0]                 rdata,
  output logic                        timeout,
  icape_warmboot_seq_if.master        wb
);

  localparam logic [TIMEOUT_LG-1:0] CNT_MAX = '1;
  localparam logic [TIMEOUT_LG-1:0] CNT_ONE = {{(TIMEOUT_LG-1){1'b0}}, 1'b1};

  logic                  cyc_reg;
  logic                  stb_reg;
  logic                  we_reg;
  logic [4:0]            addr_reg;
  logic [31:0]           data_reg;
  logic [TIMEOUT_LG-1:0] cnt_reg;

  // Acks seen while our cycle is closed belong to nobody and are dropped.
  assign ack     = cyc_reg & wb.ack;
  assign timeout = cyc_reg & ~wb.ack & (cnt_reg == CNT_MAX);
  assign rdata   = wb.rdata;

  assign wb.cyc   = cyc_reg;
  assign wb.stb   = stb_reg;
  assign wb.we    = we_reg;
  assign wb.addr  = addr_reg;
  assign wb.wdata = data_reg;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cyc_reg  <= 1'b0;
      stb_reg  <= 1'b0;
      we_reg   <= 1'b0;
      addr_reg <= '0;
      data_reg <= '0;
      cnt_reg  <= '0;
    end else if (req) begin
      cyc_reg  <= 1'b1;
      stb_reg  <= 1'b1;
      we_reg   <= we;
      addr_reg <= addr;
      data_reg <= data;
      cnt_reg  <= '0;
    end else if (cyc_reg) begin
      // One strobe per cycle: drop stb once the slave has taken it.
      if (stb_reg && !wb.stall) begin
        stb_reg <= 1'b0;
      end
      if (ack || timeout) begin
        cyc_reg <= 1'b0;
        stb_reg <= 1'b0;
      end
      if (cnt_reg != CNT_MAX) begin
        cnt_reg <= cnt_reg + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/icape_warmboot_seq.sv
// Module: icape_warmboot_seq
// Purpose: Wishbone master that performs the ICAPE2 warm-boot sequence:
//   write WBSTAR, optionally read it back and compare, then write IPROG to CMD.
//   i_clk, i_reset_n   clock, asynchronous active-low reset
//   i_start            one-cycle request, ignored while busy or on a done/err cycle
//   i_boot_addr        WBSTAR value, captured when i_start is accepted
//   o_busy             sequence in progress
//   o_done / o_err     one-cycle completion / failure pulses
//   o_err_code         0 none, 1 timeout, 2 verify mismatch; held until next start
//   o_rd_data          last WBSTAR readback
//   wb                 Wishbone master port to the ICAPE2 slave
module icape_warmboot_seq
  import icape_warmboot_seq_pkg::*;
#(
  parameter int VERIFY     = 1,
  parameter int TIMEOUT_LG = 10
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_start,
  input  logic [31:0]          i_boot_addr,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  output logic [1:0]           o_err_code,
  output logic [31:0]          o_rd_data,
  icape_warmboot_seq_if.master wb
);

  state_t      state_reg, state_next;
  logic        launched_reg;
  logic [31:0] boot_reg, boot_next;
  logic [31:0] rd_reg, rd_next;
  logic        done_reg, done_next;
  logic        err_reg, err_next;
  err_code_t   err_code_reg, err_code_next;

  logic        xact_req, xact_we, xact_ack, xact_timeout;
  logic [4:0]  xact_addr;
  logic [31:0] xact_data, xact_rdata;
  logic        in_xact;

  wb_single_xact #(.TIMEOUT_LG(TIMEOUT_LG)) u_xact (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .req       (xact_req),
    .we        (xact_we),
    .addr      (xact_addr),
    .data      (xact_data),
    .ack       (xact_ack),
    .rdata     (xact_rdata),
    .timeout   (xact_timeout),
    .wb        (wb)
  );

  assign o_busy     = (state_reg != ST_IDLE);
  assign o_done     = done_reg;
  assign o_err      = err_reg;
  assign o_err_code = err_code_reg;
  assign o_rd_data  = rd_reg;

  assign in_xact = (state_reg == ST_WR_STAR) || (state_reg == ST_RD_STAR) ||
                   (state_reg == ST_WR_CMD);

  always_comb begin
    state_next    = state_reg;
    boot_next     = boot_reg;
    rd_next       = rd_reg;
    err_code_next = err_code_reg;
    done_next     = 1'b0;
    err_next      = 1'b0;
    // The request fires in the first cycle of each transaction state, so cyc
    // rises one cycle after entry and always has a low cycle between requests.
    xact_req      = in_xact && !launched_reg;
    xact_we       = 1'b1;
    xact_addr     = REG_WBSTAR;
    xact_data     = boot_reg;

    case (state_reg)
      ST_IDLE: begin
        // A start coinciding with the done/err pulse is deliberately dropped.
        if (i_start && !done_reg && !err_reg) begin
          boot_next     = i_boot_addr;
          err_code_next = ERR_NONE;
          state_next    = ST_WR_STAR;
        end
      end
      ST_WR_STAR: begin
        if (xact_ack) begin
          state_next = (VERIFY != 0) ? ST_RD_STAR : ST_WR_CMD;
        end
      end
      ST_RD_STAR: begin
        xact_we = 1'b0;
        if (xact_ack) begin
          rd_next    = xact_rdata;
          state_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (rd_reg == boot_reg) begin
          state_next = ST_WR_CMD;
        end else begin
          err_next      = 1'b1;
          err_code_next = ERR_VERIFY;
          state_next    = ST_IDLE;
        end
      end
      ST_WR_CMD: begin
        xact_addr = REG_CMD;
        xact_data = CMD_IPROG;
        if (xact_ack) begin
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Timeout never coincides with ack, so it can simply override.
    if (in_xact && xact_timeout) begin
      err_next      = 1'b1;
      err_code_next = ERR_TIMEOUT;
      state_next    = ST_IDLE;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg    <= ST_IDLE;
      launched_reg <= 1'b0;
      boot_reg     <= '0;
      rd_reg       <= '0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      err_code_reg <= ERR_NONE;
    end else begin
      state_reg    <= state_next;
      launched_reg <= (state_next == state_reg) && (launched_reg || xact_req);
      boot_reg     <= boot_next;
      rd_reg       <= rd_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
      err_code_reg <= err_code_next;
    end
  end

endmodule

// File: tb/tb_icape_warmboot_seq.sv
// Testbench: tb_icape_warmboot_seq
// Three sequencer instances, each with a behavioural ICAPE2 slave:
//   0: VERIFY=1, TIMEOUT_LG=10, stall 3, ack 200 cycles after acceptance
//   1: VERIFY=1, TIMEOUT_LG=4,  slave never acks
//   2: VERIFY=0, TIMEOUT_LG=10, no stall, ack in the acceptance cycle
module tb_icape_warmboot_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Per-instance stimulus and slave configuration
  logic        start_r [3] = '{1'b0, 1'b0, 1'b0};
  logic [31:0] boot_r  [3] = '{32'h0, 32'h0, 32'h0};
  int          cfg_stall   [3] = '{3, 0, 0};
  int          cfg_dly     [3] = '{200, 0, 0};
  bit          cfg_noack   [3] = '{1'b0, 1'b1, 1'b0};
  bit          cfg_corrupt [3] = '{1'b0, 1'b0, 1'b0};

  // Per-instance observation
  logic        busy_w [3];
  logic        done_w [3];
  logic        err_w  [3];
  logic [1:0]  code_w [3];
  logic [31:0] rdd_w  [3];
  logic        cyc_w  [3];
  logic        stb_w  [3];
  logic        stall_w[3];
  logic [31:0] n_xact_w[3], n_rise_w[3], n_done_w[3], n_err_w[3], last_ack_w[3];
  logic [15:0][37:0] log_w [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_inst
    icape_warmboot_seq_if bus ();

    icape_warmboot_seq #(
      .VERIFY     ((gi == 2) ? 0 : 1),
      .TIMEOUT_LG ((gi == 1) ? 4 : 10)
    ) dut (
      .i_clk       (clk),
      .i_reset_n   (rst_n),
      .i_start     (start_r[gi]),
      .i_boot_addr (boot_r[gi]),
      .o_busy      (busy_w[gi]),
      .o_done      (done_w[gi]),
      .o_err       (err_w[gi]),
      .o_err_code  (code_w[gi]),
      .o_rd_data   (rdd_w[gi]),
      .wb          (bus)
    );

    int               st_cnt = 0;
    int               dcnt = 0;
    logic             pend = 1'b0;
    logic             cyc_d = 1'b0;
    logic             acc_now;
    logic [31:0]      wbstar_m = '0;
    logic [15:0][37:0] log_m = '0;
    logic [31:0]      n_xact = '0, n_rise = '0, n_done = '0, n_err = '0, last_ack = '0;

    always_comb begin
      bus.stall = bus.cyc && bus.stb && (st_cnt < cfg_stall[gi]);
      acc_now   = bus.cyc && bus.stb && !bus.stall;
      bus.ack   = !cfg_noack[gi] && bus.cyc &&
                  ((acc_now && cfg_dly[gi] == 0) || (pend && dcnt == cfg_dly[gi]));
      bus.rdata = (bus.ack && !bus.we) ? (cfg_corrupt[gi] ? 32'h0 : wbstar_m) : 32'h0;
    end

    always @(posedge clk) begin
      cyc_d <= bus.cyc;
      if (bus.cyc && !cyc_d) n_rise <= n_rise + 32'd1;
      if (done_w[gi]) n_done <= n_done + 32'd1;
      if (err_w[gi])  n_err  <= n_err + 32'd1;
      if (!bus.cyc) begin
        st_cnt <= 0;
        pend   <= 1'b0;
        dcnt   <= 0;
      end else begin
        if (bus.stb && bus.stall) st_cnt <= st_cnt + 1;
        if (acc_now) begin
          pend <= 1'b1;
          dcnt <= 1;
          if (n_xact < 32'd16) log_m[n_xact[3:0]] <= {bus.we, bus.addr, bus.wdata};
          n_xact <= n_xact + 32'd1;
          $display("[%0d] inst %0d xact %0d %s addr=%02h wdata=%08h", cyc_cnt, gi,
                   n_xact, bus.we ? "WR" : "RD", bus.addr, bus.wdata);
        end else if (pend) begin
          dcnt <= dcnt + 1;
        end
        if (bus.ack) begin
          pend     <= 1'b0;
          last_ack <= cyc_cnt;
          if (bus.we && bus.addr == 5'h10) wbstar_m <= bus.wdata;
        end
      end
    end

    assign cyc_w[gi]      = bus.cyc;
    assign stb_w[gi]      = bus.stb;
    assign stall_w[gi]    = bus.stall;
    assign n_xact_w[gi]   = n_xact;
    assign n_rise_w[gi]   = n_rise;
    assign n_done_w[gi]   = n_done;
    assign n_err_w[gi]    = n_err;
    assign last_ack_w[gi] = last_ack;
    assign log_w[gi]      = log_m;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int i, input logic [31:0] a);
    start_r[i] = 1'b1;
    boot_r[i]  = a;
    tick();
    start_r[i] = 1'b0;
  endtask

  // kind: 0 = no end within budget, 1 = done, 2 = err
  task automatic wait_end(input int i, input int budget, output int kind);
    kind = 0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (done_w[i]) begin kind = 1; break; end
      if (err_w[i])  begin kind = 2; break; end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, b, r, s, c, nd, ne;
    logic [37:0] e;

    // Reset state
    repeat (4) tick();
    check("rst busy", 64'(busy_w[0]), 64'd0);
    check("rst done", 64'(done_w[0]), 64'd0);
    check("rst err",  64'(err_w[0]),  64'd0);
    check("rst code", 64'(code_w[0]), 64'd0);
    check("rst rd",   64'(rdd_w[0]),  64'd0);
    check("rst cyc",  64'(cyc_w[0]),  64'd0);
    check("rst stb",  64'(stb_w[0]),  64'd0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Full verified sequence with a slow, stalling slave
    b = int'(n_xact_w[0]); r = int'(n_rise_w[0]);
    pulse_start(0, 32'h0040_0000);
    wait_end(0, 3000, kind);
    check("t1 end",      64'(kind), 64'd1);
    check("t1 done lat", 64'(cyc_cnt - int'(last_ack_w[0])), 64'd1);
    check("t1 busy",     64'(busy_w[0]), 64'd0);
    check("t1 code",     64'(code_w[0]), 64'd0);
    check("t1 rd_data",  64'(rdd_w[0]), 64'h0040_0000);
    check("t1 nxact",    64'(int'(n_xact_w[0]) - b), 64'd3);
    check("t1 ncyc",     64'(int'(n_rise_w[0]) - r), 64'd3);
    e = log_w[0][b];
    check("t1 x0", 64'(e), 64'({1'b1, 5'h10, 32'h0040_0000}));
    e = log_w[0][b+1];
    check("t1 x1", 64'(e[37:32]), 64'({1'b0, 5'h10}));
    e = log_w[0][b+2];
    check("t1 x2", 64'(e), 64'({1'b1, 5'h04, 32'h0000_000f}));

    // Verify mismatch: readback forced to zero, IPROG must not be issued
    repeat (3) tick();
    cfg_corrupt[0] = 1'b1;
    b = int'(n_xact_w[0]);
    pulse_start(0, 32'h0040_0000);
    wait_end(0, 3000, kind);
    check("t2 end",     64'(kind), 64'd2);
    check("t2 code",    64'(code_w[0]), 64'd2);
    check("t2 busy",    64'(busy_w[0]), 64'd0);
    check("t2 rd_data", 64'(rdd_w[0]), 64'd0);
    repeat (300) tick();
    check("t2 nxact",   64'(int'(n_xact_w[0]) - b), 64'd2);
    e = log_w[0][b];
    check("t2 x0 addr", 64'(e[36:32]), 64'h10);
    e = log_w[0][b+1];
    check("t2 x1 addr", 64'(e[36:32]), 64'h10);
    check("t2 code hold", 64'(code_w[0]), 64'd2);
    cfg_corrupt[0] = 1'b0;

    // Second start during a sequence is dropped
    b = int'(n_xact_w[0]);
    pulse_start(0, 32'h00AB_0000);
    repeat (49) tick();
    pulse_start(0, 32'hDEAD_0000);
    wait_end(0, 3000, kind);
    check("t4 end",     64'(kind), 64'd1);
    check("t4 code",    64'(code_w[0]), 64'd0);
    check("t4 nxact",   64'(int'(n_xact_w[0]) - b), 64'd3);
    check("t4 rd_data", 64'(rdd_w[0]), 64'h00AB_0000);
    e = log_w[0][b];
    check("t4 x0", 64'(e), 64'({1'b1, 5'h10, 32'h00AB_0000}));
    e = log_w[0][b+2];
    check("t4 x2", 64'(e), 64'({1'b1, 5'h04, 32'h0000_000f}));

    // Timeout: slave never acks, TIMEOUT_LG=4
    pulse_start(1, 32'h0011_0000);
    s = -1;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (stb_w[1]) begin s = cyc_cnt; break; end
    end
    check("t3 stb seen", 64'(s >= 0), 64'd1);
    c = -1;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (!cyc_w[1]) begin c = cyc_cnt; break; end
    end
    check("t3 cyc drop", 64'(c - s), 64'd16);
    check("t3 err",  64'(err_w[1]),  64'd1);
    check("t3 code", 64'(code_w[1]), 64'd1);
    check("t3 busy", 64'(busy_w[1]), 64'd0);

    // VERIFY=0, zero-wait slave acking at acceptance
    b = int'(n_xact_w[2]); r = int'(n_rise_w[2]);
    pulse_start(2, 32'h0010_0000);
    wait_end(2, 200, kind);
    check("t6 end",      64'(kind), 64'd1);
    check("t6 done lat", 64'(cyc_cnt - int'(last_ack_w[2])), 64'd1);
    check("t6 nxact",    64'(int'(n_xact_w[2]) - b), 64'd2);
    check("t6 ncyc",     64'(int'(n_rise_w[2]) - r), 64'd2);
    e = log_w[2][b];
    check("t6 x0", 64'(e), 64'({1'b1, 5'h10, 32'h0010_0000}));
    e = log_w[2][b+1];
    check("t6 x1", 64'(e), 64'({1'b1, 5'h04, 32'h0000_000f}));

    // Start held high: ignored while busy and on the done cycle, taken after
    repeat (3) tick();
    b = int'(n_xact_w[2]);
    start_r[2] = 1'b1;
    boot_r[2]  = 32'h0030_0000;
    wait_end(2, 200, kind);
    check("t7 end1",     64'(kind), 64'd1);
    check("t7 busy d",   64'(busy_w[2]), 64'd0);
    tick();
    check("t7 busy d+1", 64'(busy_w[2]), 64'd0);
    tick();
    check("t7 busy d+2", 64'(busy_w[2]), 64'd1);
    start_r[2] = 1'b0;
    wait_end(2, 200, kind);
    check("t7 end2",  64'(kind), 64'd1);
    check("t7 nxact", 64'(int'(n_xact_w[2]) - b), 64'd4);
    e = log_w[2][b+2];
    check("t7 x2", 64'(e), 64'({1'b1, 5'h10, 32'h0030_0000}));

    // Reset while stb is stalled
    repeat (3) tick();
    nd = int'(n_done_w[0]); ne = int'(n_err_w[0]);
    pulse_start(0, 32'h00C0_0000);
    s = -1;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (stall_w[0]) begin s = cyc_cnt; break; end
    end
    check("t5 stall seen", 64'(s >= 0), 64'd1);
    check("t5 stb pre",    64'(stb_w[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t5 cyc", 64'(cyc_w[0]), 64'd0);
    check("t5 stb", 64'(stb_w[0]), 64'd0);
    check("t5 busy", 64'(busy_w[0]), 64'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    check("t5 no done", 64'(int'(n_done_w[0]) - nd), 64'd0);
    check("t5 no err",  64'(int'(n_err_w[0]) - ne), 64'd0);
    b = int'(n_xact_w[0]);
    pulse_start(0, 32'h00C0_0000);
    wait_end(0, 3000, kind);
    check("t5 end",     64'(kind), 64'd1);
    check("t5 nxact",   64'(int'(n_xact_w[0]) - b), 64'd3);
    check("t5 rd_data", 64'(rdd_w[0]), 64'h00C0_0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
